// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the EX-stage control bundle
// and the branch-condition helper used by the MEM-stage branch logic.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // ALU select encoding reserved for "no operation" (bubble instructions).
    localparam logic [5:0] ALU_SEL_NOP = 6'b111111;

    // Control bits travelling with an instruction from EX into MEM.
    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic branch;
        logic branchNe;
    } ex_mem_ctrl_t;

    // Branch condition: beq takes on equality, bne on inequality.
    // When both flags are set the instruction is treated as beq.
    function automatic logic branch_taken(input logic is_beq,
                                          input logic is_bne,
                                          input logic zero_flag);
        logic taken;
        taken = 1'b0;
        if (is_beq) begin
            taken = zero_flag;
        end else if (is_bne) begin
            taken = ~zero_flag;
        end
        return taken;
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_branch_resolve.sv
// MEM-stage branch resolution: registers the branch outcome and produces a
// single-pulse PC redirect per taken branch, even across multi-cycle stalls.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic branch,
    input  logic branch_ne,
    input  logic zero_flag,
    input  logic mem_valid,
    output logic pc_src
);

    logic taken_q;
    logic redirect_done;

    // Capture the branch outcome of the EX instruction alongside the rest of the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 1'b0;
        end else if (!stall) begin
            taken_q <= branch_taken(branch, branch_ne, zero_flag);
        end
    end

    // Remember that the redirect already fired while the stage is stalled, so it is not repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_done <= 1'b0;
        end else if (!stall) begin
            redirect_done <= 1'b0;
        end else if (pc_src) begin
            redirect_done <= 1'b1;
        end
    end

    assign pc_src = mem_valid & taken_q & ~redirect_done;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register. Captures the ALU results, store data and
// control of the EX instruction, resolves branches in MEM, and squashes the
// wrong-path instruction that enters while a redirect is being issued.
module ex_mem_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  exValid,
    input  logic [DATA_W-1:0]     aluOut,
    input  logic                  zeroFlag,
    input  logic [DATA_W-1:0]     addResult,
    input  logic [DATA_W-1:0]     rtData,
    input  logic [REG_ADDR_W-1:0] writeReg,
    input  logic                  regWrite,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memToReg,
    input  logic                  branch,
    input  logic                  branchNe,
    output logic                  memValid,
    output logic [DATA_W-1:0]     memAluOut,
    output logic [DATA_W-1:0]     memRtData,
    output logic [REG_ADDR_W-1:0] memWriteReg,
    output logic                  memRegWrite,
    output logic                  memRead_o,
    output logic                  memWrite_o,
    output logic                  memToReg_o,
    output logic                  pcSrc,
    output logic [DATA_W-1:0]     branchTarget,
    output logic                  flushUp
);

    ex_mem_ctrl_t          ex_ctrl;
    logic                  mem_valid_q;
    logic [DATA_W-1:0]     alu_out_q;
    logic [DATA_W-1:0]     rt_data_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     branch_target_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  mem_to_reg_q;
    logic                  pc_src;

    assign ex_ctrl = '{regWrite: regWrite, memRead: memRead, memWrite: memWrite,
                       memToReg: memToReg, branch: branch, branchNe: branchNe};

    // Validity of the MEM instruction: the EX instruction present during a redirect is wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
        end else if (!stall) begin
            mem_valid_q <= exValid & ~pc_src;
        end
    end

    // Data fields capture every unstalled cycle, even for squashed instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q       <= '0;
            rt_data_q       <= '0;
            write_reg_q     <= '0;
            branch_target_q <= '0;
        end else if (!stall) begin
            alu_out_q       <= aluOut;
            rt_data_q       <= rtData;
            write_reg_q     <= writeReg;
            branch_target_q <= addResult;
        end
    end

    // Raw control bits; they only reach the outputs once qualified by memValid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!stall) begin
            reg_write_q  <= ex_ctrl.regWrite;
            mem_read_q   <= ex_ctrl.memRead;
            mem_write_q  <= ex_ctrl.memWrite;
            mem_to_reg_q <= ex_ctrl.memToReg;
        end
    end

    branch_resolve u_branch_resolve (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .branch    (ex_ctrl.branch),
        .branch_ne (ex_ctrl.branchNe),
        .zero_flag (zeroFlag),
        .mem_valid (mem_valid_q),
        .pc_src    (pc_src)
    );

    assign memValid     = mem_valid_q;
    assign memAluOut    = alu_out_q;
    assign memRtData    = rt_data_q;
    assign memWriteReg  = write_reg_q;
    assign branchTarget = branch_target_q;
    assign memRegWrite  = reg_write_q  & mem_valid_q;
    assign memRead_o    = mem_read_q   & mem_valid_q;
    assign memWrite_o   = mem_write_q  & mem_valid_q;
    assign memToReg_o   = mem_to_reg_q & mem_valid_q;
    assign pcSrc        = pc_src;
    assign flushUp      = pc_src;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed testbench for the EX/MEM pipeline register: reset, capture,
// squash, beq/bne resolution, stall hold with single redirect pulse,
// back-to-back branches and bubbles.
module tb_ex_mem_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        exValid;
    logic [31:0] aluOut;
    logic        zeroFlag;
    logic [31:0] addResult;
    logic [31:0] rtData;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        branch;
    logic        branchNe;
    logic        memValid;
    logic [31:0] memAluOut;
    logic [31:0] memRtData;
    logic [4:0]  memWriteReg;
    logic        memRegWrite;
    logic        memRead_o;
    logic        memWrite_o;
    logic        memToReg_o;
    logic        pcSrc;
    logic [31:0] branchTarget;
    logic        flushUp;

    int errors;
    int checks;

    ex_mem_stage_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .exValid      (exValid),
        .aluOut       (aluOut),
        .zeroFlag     (zeroFlag),
        .addResult    (addResult),
        .rtData       (rtData),
        .writeReg     (writeReg),
        .regWrite     (regWrite),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memToReg     (memToReg),
        .branch       (branch),
        .branchNe     (branchNe),
        .memValid     (memValid),
        .memAluOut    (memAluOut),
        .memRtData    (memRtData),
        .memWriteReg  (memWriteReg),
        .memRegWrite  (memRegWrite),
        .memRead_o    (memRead_o),
        .memWrite_o   (memWrite_o),
        .memToReg_o   (memToReg_o),
        .pcSrc        (pcSrc),
        .branchTarget (branchTarget),
        .flushUp      (flushUp)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one EX-stage instruction at the falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic z,
                                 input logic [31:0] add, input logic [31:0] rt,
                                 input logic [4:0] wr, input logic rw, input logic mr,
                                 input logic mw, input logic mtr, input logic br,
                                 input logic bne);
        @(negedge clk);
        exValid   = v;
        aluOut    = alu;
        zeroFlag  = z;
        addResult = add;
        rtData    = rt;
        writeReg  = wr;
        regWrite  = rw;
        memRead   = mr;
        memWrite  = mw;
        memToReg  = mtr;
        branch    = br;
        branchNe  = bne;
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        exValid = 1'b0; aluOut = '0; zeroFlag = 1'b0; addResult = '0; rtData = '0;
        writeReg = '0; regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        memToReg = 1'b0; branch = 1'b0; branchNe = 1'b0;

        #3;
        checkOutput("reset_memValid", {31'd0, memValid}, 32'd0);
        checkOutput("reset_pcSrc", {31'd0, pcSrc}, 32'd0);
        checkOutput("reset_memAluOut", memAluOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle reset while a taken branch is pending in MEM.
        applyStimulus(1'b1, 32'h0000_00AA, 1'b1, 32'h0040_0800, 32'h0000_00BB, 5'd4,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("preload_pcSrc", {31'd0, pcSrc}, 32'd1);
        checkOutput("preload_memAluOut", memAluOut, 32'h0000_00AA);
        @(negedge clk);
        stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_memValid", {31'd0, memValid}, 32'd0);
        checkOutput("midrst_pcSrc", {31'd0, pcSrc}, 32'd0);
        checkOutput("midrst_flushUp", {31'd0, flushUp}, 32'd0);
        checkOutput("midrst_memAluOut", memAluOut, 32'd0);
        checkOutput("midrst_memRtData", memRtData, 32'd0);
        checkOutput("midrst_branchTarget", branchTarget, 32'd0);
        checkOutput("midrst_ctrl", {28'd0, memRegWrite, memRead_o, memWrite_o, memToReg_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("postrst_pcSrc", {31'd0, pcSrc}, 32'd0);
        checkOutput("postrst_memValid", {31'd0, memValid}, 32'd0);

        // Plain ALU instruction with writeback.
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'd0, 32'h0000_DEAD, 5'd8,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("alu_memAluOut", memAluOut, 32'h0000_0010);
        checkOutput("alu_memWriteReg", {27'd0, memWriteReg}, 32'd8);
        checkOutput("alu_memRegWrite", {31'd0, memRegWrite}, 32'd1);
        checkOutput("alu_memRtData", memRtData, 32'h0000_DEAD);
        checkOutput("alu_pcSrc", {31'd0, pcSrc}, 32'd0);

        // Taken beq, then the wrong-path follower is squashed.
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 32'h0040_0020, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("beq_pcSrc", {31'd0, pcSrc}, 32'd1);
        checkOutput("beq_flushUp", {31'd0, flushUp}, 32'd1);
        checkOutput("beq_branchTarget", branchTarget, 32'h0040_0020);
        applyStimulus(1'b1, 32'h0000_0030, 1'b0, 32'd0, 32'd0, 5'd9,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("squash_memValid", {31'd0, memValid}, 32'd0);
        checkOutput("squash_memRegWrite", {31'd0, memRegWrite}, 32'd0);
        checkOutput("squash_memAluOut", memAluOut, 32'h0000_0030);
        checkOutput("squash_pcSrc", {31'd0, pcSrc}, 32'd0);

        // bne: equal operands do not branch, unequal operands branch once.
        applyStimulus(1'b1, 32'd0, 1'b1, 32'h0040_0100, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bne_eq_memValid", {31'd0, memValid}, 32'd1);
        checkOutput("bne_eq_pcSrc", {31'd0, pcSrc}, 32'd0);
        applyStimulus(1'b1, 32'd0, 1'b0, 32'h0040_0200, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bne_ne_pcSrc", {31'd0, pcSrc}, 32'd1);
        checkOutput("bne_ne_branchTarget", branchTarget, 32'h0040_0200);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bne_ne_pulse_end", {31'd0, pcSrc}, 32'd0);

        // Load, then a true bubble carrying stray control bits.
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 32'd0, 32'd0, 5'd12,
                      1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("load_ctrl", {28'd0, memRegWrite, memRead_o, memWrite_o, memToReg_o}, 32'hD);
        applyStimulus(1'b0, 32'h0000_2000, 1'b0, 32'd0, 32'd0, 5'd13,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bubble_memValid", {31'd0, memValid}, 32'd0);
        checkOutput("bubble_ctrl", {28'd0, memRegWrite, memRead_o, memWrite_o, memToReg_o}, 32'd0);

        // branch and branchNe both set behave as beq.
        applyStimulus(1'b1, 32'd0, 1'b0, 32'h0040_0300, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("both_ne_pcSrc", {31'd0, pcSrc}, 32'd0);
        applyStimulus(1'b1, 32'd0, 1'b1, 32'h0040_0400, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("both_eq_pcSrc", {31'd0, pcSrc}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Taken branch in MEM held by a 3-cycle stall: one pulse, frozen state.
        applyStimulus(1'b1, 32'h0000_0044, 1'b1, 32'h0040_1000, 32'h0000_0055, 5'd3,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stall_first_pcSrc", {31'd0, pcSrc}, 32'd1);
        applyStimulus(1'b0, 32'h0000_0099, 1'b0, 32'h0000_0777, 32'h0000_0888, 5'd7,
                      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_pcSrc", i), {31'd0, pcSrc}, 32'd0);
            checkOutput($sformatf("stall%0d_memValid", i), {31'd0, memValid}, 32'd1);
            checkOutput($sformatf("stall%0d_memAluOut", i), memAluOut, 32'h0000_0044);
            checkOutput($sformatf("stall%0d_memRtData", i), memRtData, 32'h0000_0055);
            checkOutput($sformatf("stall%0d_memWriteReg", i), {27'd0, memWriteReg}, 32'd3);
            checkOutput($sformatf("stall%0d_branchTarget", i), branchTarget, 32'h0040_1000);
            checkOutput($sformatf("stall%0d_memRegWrite", i), {31'd0, memRegWrite}, 32'd1);
        end
        @(negedge clk);
        stall = 1'b0;
        tick();
        checkOutput("unstall_pcSrc", {31'd0, pcSrc}, 32'd0);
        checkOutput("unstall_memValid", {31'd0, memValid}, 32'd0);

        // Back-to-back taken beq: only the first redirects.
        applyStimulus(1'b1, 32'd0, 1'b1, 32'h0000_0200, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_first_pcSrc", {31'd0, pcSrc}, 32'd1);
        checkOutput("b2b_first_target", branchTarget, 32'h0000_0200);
        applyStimulus(1'b1, 32'd0, 1'b1, 32'h0000_0300, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_second_memValid", {31'd0, memValid}, 32'd0);
        checkOutput("b2b_second_pcSrc", {31'd0, pcSrc}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_after_pcSrc", {31'd0, pcSrc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
